logic_gate_pipe: RTL and testbench
==================================

Name: logic_gate_pipe

Overview:
- Parametrised, pipelined successor to the team's two-input AND gate primitive.
- Applies a selectable bitwise or reduction operation across NUM_IN operands, each WIDTH bits wide.
- Two register stages with a valid/ready handshake on both sides, plus a completed-transfer counter.
- Sits between the tutorial stimulus sources and the display/LED sink logic.

Parameters:
- WIDTH, 8, bit width of each operand and of the result.
- NUM_IN, 2, number of operands; legal range 2..8.
- COUNT_W, 16, width of the transfer counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data and in_op are valid this cycle.
- in_ready  out  1  block accepts input this cycle.
- in_data  in  NUM_IN*WIDTH  packed operands; operand k occupies bits [k*WIDTH +: WIDTH].
- in_op  in  3  operation: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 REDUCE_AND, 7 REDUCE_XOR.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  WIDTH  result.
- xfer_count  out  COUNT_W  number of completed output handshakes.

Behaviour:
- Reset (asynchronous assert, synchronous release by clk): s1_valid=0, s2_valid=0, out_valid=0, out_data=0, xfer_count=0, all stage data registers 0.
- Handshakes:
  - Input accept: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
  - out_valid equals s2_valid; out_data is the S2 data register.
- Stage 1 (S1) loads on input accept:
  - S1 data = bitwise fold of all NUM_IN operands using the base op: AND for ops 0/3/6, OR for 1/4, XOR for 2/5/7.
  - in_op is registered alongside the data.
- Stage 2 (S2) loads from S1 when S1 is valid and S2 can advance:
  - Ops 0–2: pass the S1 data through.
  - Ops 3–5: bitwise invert the S1 data.
  - Op 6: out_data = {WIDTH-1 zeros, &S1}.
  - Op 7: out_data = {WIDTH-1 zeros, ^S1}.
- Advance conditions (combinational ready path allowed):
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv
- Valid updates:
  - s1_valid <= in_valid when s1_adv; otherwise it holds.
  - s2_valid <= s1_valid when s2_adv; otherwise it holds.
- Latency: 2 cycles from input accept to out_valid when unstalled. Throughput is 1 transfer per cycle.
- Stall:
  - out_valid && !out_ready holds out_data and s2_valid stable.
  - If S1 is also valid, in_ready=0.
  - No data is lost or duplicated.
  - Both stages hold data while stalled, so total buffering is 2 entries.
- in_data and in_op are ignored when in_valid=0 or in_ready=0; upstream must hold them stable until accepted.
- xfer_count increments by 1 on each output transfer and wraps from 2^COUNT_W-1 to 0.
- Simultaneous events:
  - An output transfer and an S1-to-S2 load in the same cycle are legal and produce back-to-back results.
  - An input accept while S1 empties in the same cycle is legal.
- Reset mid-operation: in-flight data is discarded, out_valid drops immediately (asynchronously), and the counter clears.
- WIDTH=1, NUM_IN=2, op 0 must behave exactly as a registered two-input AND.

Test Plan:
- Reset and basic AND:
  - Stimulus: rst_n low, then release; WIDTH=8, NUM_IN=2; operands 8'hF0 and 8'h3C, op 0; out_ready=1.
  - Required: out_valid=0 during reset; out_data=8'h30 with out_valid=1 exactly 2 cycles after the accept; xfer_count=1.
- All ops, NUM_IN=3, operands 8'hAA, 8'hCC, 8'hF0, ops 0..7. Required results:
  - op 0: 8'h80; op 1: 8'hFE; op 2: 8'h96.
  - op 3: 8'h7F; op 4: 8'h01; op 5: 8'h69.
  - op 6: 8'h00; op 7: 8'h00 (parity of 8'h96 is 0).
  - Repeat op 7 with operands 8'h01, 8'h00, 8'h00: expect 8'h01.
- Backpressure:
  - Stimulus: stream 4 values 1..4 with op 1 and the other operand 0; hold out_ready=0 for 5 cycles, then set it to 1.
  - Required: in_ready=0 after 2 accepts; outputs arrive as 1, 2, 3, 4 in order with no loss or duplication; out_data stable while stalled.
- Full throughput:
  - Stimulus: in_valid=1 and out_ready=1 for 100 cycles.
  - Required: in_ready stays 1; 98 transfers complete by cycle 100; xfer_count=98.
- Counter wrap:
  - Stimulus: COUNT_W=4; perform 17 transfers.
  - Required: xfer_count=1.
- Mid-stream reset:
  - Stimulus: assert rst_n low between clock edges while both stages are valid.
  - Required: out_valid=0 and xfer_count=0 immediately; first output after release comes from the first post-reset input.

Source files
------------

// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: two-stage valid/ready pipeline applying a selectable bitwise or reduction op across NUM_IN operands.
module logic_gate_pipe #(
    parameter int WIDTH   = 8,
    parameter int NUM_IN  = 2,
    parameter int COUNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [2:0]              in_op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [COUNT_W-1:0]      xfer_count
);
    logic               s1_valid_q, s2_valid_q, s1_adv, s2_adv;
    logic [WIDTH-1:0]   s1_data_q, s1_data_d, s2_data_q, s2_data_d;
    logic [2:0]         s1_op_q;
    logic [COUNT_W-1:0] cnt_q;

    assign s2_adv     = !s2_valid_q || out_ready;
    assign s1_adv     = !s1_valid_q || s2_adv;
    assign in_ready   = s1_adv;
    assign out_valid  = s2_valid_q;
    assign out_data   = s2_data_q;
    assign xfer_count = cnt_q;

    // S1 folds with the base op; inversion and reduction are deferred to S2
    always_comb begin
        s1_data_d = in_data[WIDTH-1:0];
        for (int k = 1; k < NUM_IN; k++) begin
            s1_data_d = (in_op == 3'd0 || in_op == 3'd3 || in_op == 3'd6) ? s1_data_d & in_data[k*WIDTH +: WIDTH]
                      : (in_op == 3'd1 || in_op == 3'd4) ? s1_data_d | in_data[k*WIDTH +: WIDTH]
                      : s1_data_d ^ in_data[k*WIDTH +: WIDTH];
        end
    end

    always_comb
        s2_data_d = (s1_op_q < 3'd3) ? s1_data_q
                  : (s1_op_q < 3'd6) ? ~s1_data_q
                  : (s1_op_q == 3'd6) ? WIDTH'(&s1_data_q)
                  : WIDTH'(^s1_data_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_op_q    <= '0;
            s2_data_q  <= '0;
            cnt_q      <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_data_q <= s1_data_d;
                    s1_op_q   <= in_op;
                end
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) s2_data_q <= s2_data_d;
            end
            if (s2_valid_q && out_ready) cnt_q <= cnt_q + COUNT_W'(1);
        end
    end
endmodule

// File: tb/tb_logic_gate_pipe.sv
// tb_logic_gate_pipe: vector table, hand sequences and randomized scoreboard for logic_gate_pipe.
module tb_logic_gate_pipe;
    logic        clk, rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [23:0] in_data;
    logic [2:0]  in_op;
    logic [7:0]  out_data;
    logic [15:0] xfer_count;

    logic       w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic [1:0] w_in_data;
    logic [2:0] w_in_op;
    logic [0:0] w_out_data;
    logic [3:0] w_xfer;

    logic_gate_pipe #(.WIDTH(8), .NUM_IN(3), .COUNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .xfer_count(xfer_count)
    );

    logic_gate_pipe #(.WIDTH(1), .NUM_IN(2), .COUNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_data(w_in_data), .in_op(w_in_op), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_data(w_out_data), .xfer_count(w_xfer)
    );

    typedef struct {
        logic [23:0] data;
        logic [2:0]  op;
        logic [7:0]  exp;
    } vec_t;

    vec_t       vecs [9];
    logic [7:0] q [$];
    logic       wq [$];
    int         total, passed, model_cnt, nxt, bad;
    bit         acc, xf;
    logic [7:0] last_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else passed++;
    endtask

    // Per-bit population count gives AND/OR/XOR; reductions use the count over all operand bits
    function automatic logic [7:0] ref_model(input logic [23:0] d, input logic [2:0] op);
        logic [7:0] f;
        int n, tot;
        tot = 0;
        for (int b = 0; b < 8; b++) begin
            n = 0;
            for (int k = 0; k < 3; k++) n += int'(d[k*8+b]);
            tot += n;
            f[b] = (op == 3'd0 || op == 3'd3) ? (n == 3) : (op == 3'd1 || op == 3'd4) ? (n != 0) : n[0];
        end
        return (op == 3'd6) ? 8'(tot == 24) : (op == 3'd7) ? 8'(tot % 2) : (op >= 3'd3) ? ~f : f;
    endfunction

    task automatic tick();
        logic [7:0] e;
        #1;
        acc = in_valid && in_ready;
        xf  = out_valid && out_ready;
        if (xf) begin
            if (q.size() == 0) begin
                total++;
                $display("FAIL out_unexpected: got %0h, expected no output", out_data);
            end else begin
                e = q.pop_front();
                chk("out_data", 32'(out_data), 32'(e));
            end
            last_out = out_data;
            model_cnt++;
        end
        if (acc) q.push_back(ref_model(in_data, in_op));
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [23:0] d, input logic [2:0] op);
        bit done;
        done     = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_op    = op;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            done = acc;
        end
        in_valid = 1'b0;
        chk("send_accepted", 32'(done), 32'd1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (q.size() != 0 || out_valid); i++) tick();
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    task automatic do_reset();
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        w_in_valid = 1'b0;
        rst_n      = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_xfer", 32'(xfer_count), 32'd0);
        q.delete();
        wq.delete();
        model_cnt = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0; passed = 0; model_cnt = 0;
        in_data = '0; in_op = '0; w_in_data = '0; w_in_op = '0; w_out_ready = 1'b1;
        vecs[0] = '{24'hF0CCAA, 3'd0, 8'h80};
        vecs[1] = '{24'hF0CCAA, 3'd1, 8'hFE};
        vecs[2] = '{24'hF0CCAA, 3'd2, 8'h96};
        vecs[3] = '{24'hF0CCAA, 3'd3, 8'h7F};
        vecs[4] = '{24'hF0CCAA, 3'd4, 8'h01};
        vecs[5] = '{24'hF0CCAA, 3'd5, 8'h69};
        vecs[6] = '{24'hF0CCAA, 3'd6, 8'h00};
        vecs[7] = '{24'hF0CCAA, 3'd7, 8'h00};
        vecs[8] = '{24'h000001, 3'd7, 8'h01};

        do_reset();
        chk("rst_out_data", 32'(out_data), 32'd0);

        // basic AND (third operand all ones) with exact latency
        in_valid = 1'b1; in_data = 24'hFF3CF0; in_op = 3'd0;
        tick();
        chk("and_accept", 32'(acc), 32'd1);
        in_valid = 1'b0;
        chk("and_lat1_valid", 32'(out_valid), 32'd0);
        tick();
        chk("and_lat2_valid", 32'(out_valid), 32'd1);
        chk("and_lat2_data", 32'(out_data), 32'h30);
        tick();
        chk("and_xfer", 32'(xfer_count), 32'd1);

        foreach (vecs[i]) begin
            send(vecs[i].data, vecs[i].op);
            drain();
            chk($sformatf("vec%0d_op%0d", i, vecs[i].op), 32'(last_out), 32'(vecs[i].exp));
        end
        chk("vec_xfer", 32'(xfer_count), 32'(16'(model_cnt)));

        // backpressure: two entries buffered, then in_ready drops
        out_ready = 1'b0; in_op = 3'd1; nxt = 1; in_data = 24'(nxt); in_valid = 1'b1;
        tick(); chk("bp_acc1", 32'(acc), 32'd1); nxt++; in_data = 24'(nxt);
        tick(); chk("bp_acc2", 32'(acc), 32'd1); nxt++; in_data = 24'(nxt);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (in_ready || !out_valid || out_data != 8'h01) bad++;
            tick();
        end
        chk("bp_stall_stable", 32'(bad), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 20 && nxt <= 4; i++) begin
            tick();
            if (acc) begin nxt++; in_data = 24'(nxt); end
        end
        in_valid = 1'b0;
        drain();
        chk("bp_all_sent", 32'(nxt), 32'd5);
        chk("bp_last", 32'(last_out), 32'd4);

        // randomized traffic against the scoreboard
        in_valid = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(3) != 0);
                in_data  = 24'($urandom);
                in_op    = 3'($urandom);
            end
            out_ready = ($urandom_range(2) != 0);
            tick();
        end
        in_valid = 1'b0;
        drain();
        chk("rand_xfer", 32'(xfer_count), 32'(16'(model_cnt)));

        // full throughput
        do_reset();
        in_valid = 1'b1; out_ready = 1'b1; bad = 0;
        for (int c = 0; c < 100; c++) begin
            in_data = 24'($urandom);
            in_op   = 3'($urandom);
            if (!in_ready) bad++;
            tick();
        end
        chk("thru_ready_drops", 32'(bad), 32'd0);
        chk("thru_xfer98", 32'(xfer_count), 32'd98);
        in_valid = 1'b0;
        drain();

        // 1-bit registered AND and 4-bit counter wrap
        do_reset();
        w_out_ready = 1'b1; w_in_op = 3'd0; bad = 0;
        for (int c = 0; c < 19; c++) begin
            w_in_valid = (c < 17);
            w_in_data  = 2'(c);
            #1;
            if (w_out_valid) begin
                if (wq.size() == 0) bad++;
                else chk("w_and", 32'(w_out_data), 32'(wq.pop_front()));
            end
            if (w_in_valid && w_in_ready) wq.push_back(w_in_data[0] & w_in_data[1]);
            @(posedge clk);
            #1;
        end
        w_in_valid = 1'b0;
        chk("w_no_extra", 32'(bad), 32'd0);
        chk("w_drained", 32'(wq.size()), 32'd0);
        chk("w_wrap", 32'(w_xfer), 32'd1);

        // mid-stream reset with both stages full
        send(24'h00_00_5A, 3'd1);
        drain();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 24'h123456; in_op = 3'd2;
        tick();
        in_data = 24'h654321;
        tick();
        chk("mid_full_ready", 32'(in_ready), 32'd0);
        chk("mid_full_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_out_valid", 32'(out_valid), 32'd0);
        chk("mid_xfer", 32'(xfer_count), 32'd0);
        q.delete();
        model_cnt = 0;
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(24'hF0_0F_33, 3'd2);
        drain();
        chk("mid_first_out", 32'(last_out), 32'(8'hCC));
        chk("mid_xfer_after", 32'(xfer_count), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
